// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : Bundles the WB-stage buses: the MEM->WB pipeline handshake,
//               the long-latency unit valid/ready channel, the register-file
//               write port, the decode forwarding bus and the FIFO busy flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports:
//   master : environment side (MEM stage, long-latency unit, register file,
//            decode stage) - drives ms_* / lu_*, observes everything else.
//   slave  : wb_stage side - consumes ms_* / lu_*, drives allowin, lu_ready,
//            rf_*, ws_fwd_* and lq_busy.
// Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* trace signals.
// ============================================================================
interface wb_stage_if;
  // MEM -> WB pipeline handshake
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  // Long-latency unit channel
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_result;
  // Register file write port
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  // Forwarding bus and decode interlock
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic        lq_busy;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
    output lu_valid, lu_dest, lu_result,
    input  ws_allowin, lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  ws_fwd_valid, ws_fwd_dest, ws_fwd_data, lq_busy
`ifdef WB_DEBUG_TRACE_EN
    ,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
    input  lu_valid, lu_dest, lu_result,
    output ws_allowin, lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output ws_fwd_valid, ws_fwd_dest, ws_fwd_data, lq_busy
`ifdef WB_DEBUG_TRACE_EN
    ,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : MIPS write-back stage. Sole owner of the register-file write
//               port. Merges in-order MEM-stage results (valid/allowin) with
//               out-of-band long-latency results buffered in a small FIFO
//               (valid/ready), and mirrors the write port onto the decode
//               forwarding bus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    : core clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : wb_stage_if.slave
//            in  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result
//            out ws_allowin
//            in  lu_valid, lu_dest, lu_result ; out lu_ready
//            out rf_we, rf_waddr, rf_wdata
//            out ws_fwd_valid, ws_fwd_dest, ws_fwd_data, lq_busy
// Parameters:
//   LQ_DEPTH : long-latency FIFO entries (power of two, >= 2)
//   LQ_AW    : FIFO pointer width, log2(LQ_DEPTH)
// Optional macro WB_DEBUG_TRACE_EN: adds debug_wb_pc, debug_wb_rf_wen,
//   debug_wb_rf_wnum, debug_wb_rf_wdata on the interface.
// ============================================================================
module wb_stage #(
  parameter int LQ_DEPTH = 2,
  parameter int LQ_AW    = 1
) (
  input  wire logic  clk,
  input  wire logic  resetn,
  wb_stage_if.slave  bus
);

  localparam logic [LQ_AW:0]   CNT_FULL = LQ_DEPTH[LQ_AW:0];
  localparam logic [LQ_AW:0]   CNT_ONE  = 1;
  localparam logic [LQ_AW-1:0] PTR_ONE  = 1;

  // WB pipeline register
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;

  // Long-latency FIFO
  logic [4:0]       lq_dest [LQ_DEPTH];
  logic [31:0]      lq_data [LQ_DEPTH];
  logic [LQ_AW-1:0] rd_ptr;
  logic [LQ_AW-1:0] wr_ptr;
  logic [LQ_AW:0]   count;

  logic        lq_full;
  logic        lq_empty;
  logic [4:0]  head_dest;
  logic [31:0] head_data;
  logic        push;
  logic        pop;

  logic        ws_wr;
  logic        ws_ready_go;
  logic        allowin;
  logic        wr_en;
  logic        wr_from_pipe;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign lq_full   = (count == CNT_FULL);
  assign lq_empty  = (count == '0);
  assign head_dest = lq_dest[rd_ptr];
  assign head_data = lq_data[rd_ptr];
  assign push      = bus.lu_valid & ~lq_full;

  // r0 is hard-wired zero, so a pipeline result targeting it is never written.
  assign ws_wr   = ws_valid & ws_gr_we & (ws_dest != 5'd0);
  assign allowin = ~ws_valid | ws_ready_go;

  // Write-port arbitration. The pipeline normally wins, but once the FIFO is
  // full its head takes the port and the WB instruction stalls one cycle, so
  // a steady pipeline write stream cannot starve the long-latency unit.
  // Address/data are forced to zero whenever nothing is written.
  always_comb begin
    pop          = 1'b0;
    ws_ready_go  = 1'b1;
    wr_en        = 1'b0;
    wr_from_pipe = 1'b0;
    wr_addr      = 5'd0;
    wr_data      = 32'd0;
    if (lq_full && ws_wr) begin
      pop         = 1'b1;
      ws_ready_go = 1'b0;
      if (head_dest != 5'd0) begin
        wr_en   = 1'b1;
        wr_addr = head_dest;
        wr_data = head_data;
      end
    end else if (ws_wr) begin
      wr_en        = 1'b1;
      wr_from_pipe = 1'b1;
      wr_addr      = ws_dest;
      wr_data      = ws_result;
    end else if (!lq_empty) begin
      // Entries aimed at r0 still drain, they just produce no write.
      pop = 1'b1;
      if (head_dest != 5'd0) begin
        wr_en   = 1'b1;
        wr_addr = head_dest;
        wr_data = head_data;
      end
    end
  end

  // Pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid  <= 1'b0;
      ws_pc     <= 32'd0;
      ws_gr_we  <= 1'b0;
      ws_dest   <= 5'd0;
      ws_result <= 32'd0;
    end else begin
      if (allowin) begin
        ws_valid <= bus.ms_to_ws_valid;
      end
      if (bus.ms_to_ws_valid && allowin) begin
        ws_pc     <= bus.ms_pc;
        ws_gr_we  <= bus.ms_gr_we;
        ws_dest   <= bus.ms_dest;
        ws_result <= bus.ms_result;
      end
    end
  end

  // FIFO storage needs no reset: an entry is only read while count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_dest[wr_ptr] <= bus.lu_dest;
      lq_data[wr_ptr] <= bus.lu_result;
    end
  end

  // FIFO pointers wrap naturally because LQ_DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Outputs are combinational from state, so rf_we drops as soon as resetn
  // clears ws_valid and count.
  assign bus.ws_allowin   = allowin;
  assign bus.lu_ready     = ~lq_full;
  assign bus.lq_busy      = ~lq_empty;
  assign bus.rf_we        = wr_en;
  assign bus.rf_waddr     = wr_addr;
  assign bus.rf_wdata     = wr_data;
  assign bus.ws_fwd_valid = wr_en;
  assign bus.ws_fwd_dest  = wr_addr;
  assign bus.ws_fwd_data  = wr_data;

`ifdef WB_DEBUG_TRACE_EN
  // FIFO writes have no meaningful PC, so they are tagged with all-ones.
  assign bus.debug_wb_pc       = !wr_en       ? 32'd0 :
                                 wr_from_pipe ? ws_pc : 32'hFFFF_FFFF;
  assign bus.debug_wb_rf_wen   = {4{wr_en}};
  assign bus.debug_wb_rf_wnum  = wr_addr;
  assign bus.debug_wb_rf_wdata = wr_data;
`else
  // The latched PC is only observable through the debug trace.
  logic unused_pc;
  assign unused_pc = ^{ws_pc, wr_from_pipe};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage. Directed stimulus pushes
//               the expected register-file writes into a scoreboard queue; an
//               independent monitor pops and compares every write the DUT
//               presents. Point checks cover handshake/interlock outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  wb_stage_if ifc ();

  wb_stage #(.LQ_DEPTH(2), .LQ_AW(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] d, input logic [31:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic ms_send(input logic v, input logic [4:0] d, input logic [31:0] r);
    ifc.ms_to_ws_valid = v;
    ifc.ms_gr_we       = 1'b1;
    ifc.ms_dest        = d;
    ifc.ms_result      = r;
  endtask

  task automatic lu_send(input logic v, input logic [4:0] d, input logic [31:0] r);
    ifc.lu_valid  = v;
    ifc.lu_dest   = d;
    ifc.lu_result = r;
  endtask

  // Scoreboard monitor: every write seen out of reset must match the queue head.
  always @(negedge clk) begin
    if (resetn && ifc.rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected none @%0t",
                 ifc.rf_waddr, ifc.rf_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, ifc.rf_waddr}, {27'd0, e.dest});
        chk("wr_data", ifc.rf_wdata, e.data);
        chk("fwd_valid", {31'd0, ifc.ws_fwd_valid}, 32'd1);
        chk("fwd_dest", {27'd0, ifc.ws_fwd_dest}, {27'd0, e.dest});
        chk("fwd_data", ifc.ws_fwd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.ms_to_ws_valid = 1'b0;
    ifc.ms_pc          = 32'd0;
    ifc.ms_gr_we       = 1'b0;
    ifc.ms_dest        = 5'd0;
    ifc.ms_result      = 32'd0;
    lu_send(1'b0, 5'd0, 32'd0);

    // ---- reset state
    #2;
    chk("rst_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    chk("rst_allowin", {31'd0, ifc.ws_allowin}, 32'd1);
    chk("rst_lu_ready", {31'd0, ifc.lu_ready}, 32'd1);
    chk("rst_lq_busy", {31'd0, ifc.lq_busy}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;

    // ---- pipeline write to r5, visible the cycle after acceptance
    ifc.ms_pc = 32'hBFC0_0000;
    ms_send(1'b1, 5'd5, 32'h0000_1234);
    expect_wr(5'd5, 32'h0000_1234);
    chk("p1_pre_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    tick();
    ifc.ms_to_ws_valid = 1'b0;
    chk("p1_rf_we", {31'd0, ifc.rf_we}, 32'd1);
    tick();

    // ---- pipeline write to r0 is suppressed
    ms_send(1'b1, 5'd0, 32'h5555_5555);
    chk("r0_allowin_a", {31'd0, ifc.ws_allowin}, 32'd1);
    tick();
    ifc.ms_to_ws_valid = 1'b0;
    chk("r0_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    chk("r0_allowin_b", {31'd0, ifc.ws_allowin}, 32'd1);
    tick();
    chk("r0_allowin_c", {31'd0, ifc.ws_allowin}, 32'd1);

    // ---- single long-latency result while WB idle: one-cycle latency
    lu_send(1'b1, 5'd8, 32'h0000_DEAD);
    expect_wr(5'd8, 32'h0000_DEAD);
    chk("lu1_ready", {31'd0, ifc.lu_ready}, 32'd1);
    chk("lu1_no_same_cycle", {31'd0, ifc.rf_we}, 32'd0);
    tick();
    ifc.lu_valid = 1'b0;
    chk("lu1_rf_we", {31'd0, ifc.rf_we}, 32'd1);
    chk("lu1_busy_hi", {31'd0, ifc.lq_busy}, 32'd1);
    tick();
    chk("lu1_busy_lo", {31'd0, ifc.lq_busy}, 32'd0);
    chk("lu1_rf_we_lo", {31'd0, ifc.rf_we}, 32'd0);

    // ---- long-latency entry to r0 is accepted then dropped
    lu_send(1'b1, 5'd0, 32'h0000_0077);
    tick();
    ifc.lu_valid = 1'b0;
    chk("lu0_busy", {31'd0, ifc.lq_busy}, 32'd1);
    chk("lu0_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    tick();
    chk("lu0_busy_lo", {31'd0, ifc.lq_busy}, 32'd0);

    // ---- FIFO fills while MEM streams writes to r3; head wins when full
    expect_wr(5'd3, 32'h0000_0300);
    expect_wr(5'd3, 32'h0000_0301);
    expect_wr(5'd10, 32'h0000_00A1);
    expect_wr(5'd3, 32'h0000_0302);
    expect_wr(5'd3, 32'h0000_0303);
    expect_wr(5'd11, 32'h0000_00B2);
    ms_send(1'b1, 5'd3, 32'h0000_0300);
    tick();
    ms_send(1'b1, 5'd3, 32'h0000_0301);
    lu_send(1'b1, 5'd10, 32'h0000_00A1);
    chk("arb_lu_ready_a", {31'd0, ifc.lu_ready}, 32'd1);
    tick();
    ms_send(1'b1, 5'd3, 32'h0000_0302);
    lu_send(1'b1, 5'd11, 32'h0000_00B2);
    tick();
    lu_send(1'b0, 5'd0, 32'd0);
    ms_send(1'b1, 5'd3, 32'h0000_0303);
    chk("arb_full_allowin", {31'd0, ifc.ws_allowin}, 32'd0);
    chk("arb_full_lu_ready", {31'd0, ifc.lu_ready}, 32'd0);
    chk("arb_full_waddr", {27'd0, ifc.rf_waddr}, 32'd10);
    tick();
    chk("arb_held_allowin", {31'd0, ifc.ws_allowin}, 32'd1);
    chk("arb_held_wdata", ifc.rf_wdata, 32'h0000_0302);
    tick();
    ifc.ms_to_ws_valid = 1'b0;
    tick();
    chk("arb_drain_busy", {31'd0, ifc.lq_busy}, 32'd1);
    chk("arb_drain_waddr", {27'd0, ifc.rf_waddr}, 32'd11);
    tick();
    chk("arb_empty_busy", {31'd0, ifc.lq_busy}, 32'd0);

    // ---- push+pop each cycle at count=1, ten pushes wrap the pointers
    for (int i = 0; i < 10; i++) begin
      lu_send(1'b1, 5'(i + 1), 32'hC000_0000 + 32'(i));
      expect_wr(5'(i + 1), 32'hC000_0000 + 32'(i));
      if (i > 0) begin
        chk("wrap_busy", {31'd0, ifc.lq_busy}, 32'd1);
        chk("wrap_lu_ready", {31'd0, ifc.lu_ready}, 32'd1);
      end
      tick();
    end
    ifc.lu_valid = 1'b0;
    chk("wrap_last_busy", {31'd0, ifc.lq_busy}, 32'd1);
    tick();
    chk("wrap_done_busy", {31'd0, ifc.lq_busy}, 32'd0);

    // ---- reset dropped mid-burst with two FIFO entries
    expect_wr(5'd3, 32'h0000_0400);
    expect_wr(5'd3, 32'h0000_0401);
    ms_send(1'b1, 5'd3, 32'h0000_0400);
    tick();
    ms_send(1'b1, 5'd3, 32'h0000_0401);
    lu_send(1'b1, 5'd12, 32'h0000_00E1);
    tick();
    ms_send(1'b1, 5'd3, 32'h0000_0402);
    lu_send(1'b1, 5'd13, 32'h0000_00E2);
    tick();
    lu_send(1'b0, 5'd0, 32'd0);
    ifc.ms_to_ws_valid = 1'b0;
    chk("mid_full_busy", {31'd0, ifc.lq_busy}, 32'd1);
    chk("mid_full_lu_ready", {31'd0, ifc.lu_ready}, 32'd0);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, ifc.lq_busy}, 32'd0);
    chk("mid_rst_allowin", {31'd0, ifc.ws_allowin}, 32'd1);
    tick();
    tick();
    resetn = 1'b1;
    chk("post_rst_busy", {31'd0, ifc.lq_busy}, 32'd0);
    chk("post_rst_lu_ready", {31'd0, ifc.lu_ready}, 32'd1);
    chk("post_rst_rf_we", {31'd0, ifc.rf_we}, 32'd0);
    repeat (4) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
